// File: rtl/probe_pkg.sv
// Shared types and defaults for the logic-probe input conditioner.
// PROBE_FAULT_DETECT_EN selects whether filtered HI+LO is reported as FAULT or as ONE.
package probe_pkg;

  typedef enum logic [1:0] {
    LVL_FLOAT = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_ZERO  = 2'd2,
    LVL_FAULT = 2'd3
  } level_t;

  typedef logic [2:0] edge_state_t;
  localparam edge_state_t ST_IDLE         = 3'd0;
  localparam edge_state_t ST_AT_ZERO      = 3'd1;
  localparam edge_state_t ST_AT_ONE       = 3'd2;
  localparam edge_state_t ST_TRANSIT_UP   = 3'd3;
  localparam edge_state_t ST_TRANSIT_DOWN = 3'd4;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILTER_CYCLES  = 4;
  localparam int DEF_TRANSIT_MAX    = 8;
  localparam int DEF_STRETCH_CYCLES = 2500000;
  localparam int DEF_COUNT_WIDTH    = 16;

  // HI has priority over LO unless simultaneous assertion is to be flagged.
  function automatic level_t classify_level(input logic hi, input logic lo);
    level_t lvl;
    case ({hi, lo})
      2'b10:   lvl = LVL_ONE;
      2'b01:   lvl = LVL_ZERO;
`ifdef PROBE_FAULT_DETECT_EN
      2'b11:   lvl = LVL_FAULT;
`else
      2'b11:   lvl = LVL_ONE;
`endif
      default: lvl = LVL_FLOAT;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/probe_sync_filter.sv
// One comparator channel: multi-flop synchroniser followed by a persistence filter.
// The filtered value only follows the synced value after FILTER_CYCLES consecutive disagreements.
module probe_sync_filter
  import probe_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CntW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CntW'(FILTER_CYCLES - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/probe_input_conditioner.sv
// Logic-probe front end: conditions COMP_HI/COMP_LO, classifies the level and counts qualified edges.
// Build option PROBE_FAULT_DETECT_EN enables FAULT classification and the sticky fault flag.
module probe_input_conditioner
  import probe_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int TRANSIT_MAX    = DEF_TRANSIT_MAX,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   pulse_reset,
  input  logic                   comp_hi_raw,
  input  logic                   comp_lo_raw,
  input  logic                   clear,
  output logic                   comp_data_hi,
  output logic                   comp_data_lo,
  output logic [1:0]             level_state,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic                   pulse_seen,
  output logic [COUNT_WIDTH-1:0] edge_count,
  output logic                   fault
);

  localparam int TrW = $clog2(TRANSIT_MAX + 2);
  localparam int StW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [TrW-1:0] TransitLimit = TrW'(TRANSIT_MAX);
  localparam logic [TrW-1:0] TransitSat   = TrW'(TRANSIT_MAX + 1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  level_t                 lvl_d, lvl_q;
  edge_state_t            state_d, state_q;
  logic [TrW-1:0]         transit_d, transit_q;
  logic                   rise_d, rise_q, fall_d, fall_q, strobe;
  logic [StW-1:0]         stretch_d, stretch_q;
  logic [COUNT_WIDTH-1:0] ecount_d, ecount_q;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge pulse_reset) begin
    if (!pulse_reset) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  probe_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .raw_i(comp_hi_raw), .filt_o(comp_data_hi)
  );
  probe_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .raw_i(comp_lo_raw), .filt_o(comp_data_lo)
  );

  assign lvl_d = classify_level(comp_data_hi, comp_data_lo);

  // A change between solid levels is an edge only if the FLOAT gap fits the transit window.
  always_comb begin
    state_d   = state_q;
    transit_d = transit_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lvl_d == LVL_ONE)       state_d = ST_AT_ONE;
        else if (lvl_d == LVL_ZERO) state_d = ST_AT_ZERO;
      end
      ST_AT_ZERO: begin
        if (lvl_d == LVL_ONE) begin
          state_d = ST_AT_ONE;
          rise_d  = 1'b1;
        end else if (lvl_d == LVL_FLOAT) begin
          state_d   = ST_TRANSIT_UP;
          transit_d = '0;
        end
      end
      ST_TRANSIT_UP: begin
        if (lvl_d == LVL_ONE) begin
          state_d = ST_AT_ONE;
          rise_d  = (transit_q <= TransitLimit);
        end else if (lvl_d == LVL_ZERO) begin
          state_d = ST_AT_ZERO;
        end else if (transit_q != TransitSat) begin
          transit_d = transit_q + 1'b1;
        end
      end
      ST_AT_ONE: begin
        if (lvl_d == LVL_ZERO) begin
          state_d = ST_AT_ZERO;
          fall_d  = 1'b1;
        end else if (lvl_d == LVL_FLOAT) begin
          state_d   = ST_TRANSIT_DOWN;
          transit_d = '0;
        end
      end
      ST_TRANSIT_DOWN: begin
        if (lvl_d == LVL_ZERO) begin
          state_d = ST_AT_ZERO;
          fall_d  = (transit_q <= TransitLimit);
        end else if (lvl_d == LVL_ONE) begin
          state_d = ST_AT_ONE;
        end else if (transit_q != TransitSat) begin
          transit_d = transit_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef PROBE_FAULT_DETECT_EN
    if (lvl_d == LVL_FAULT) begin
      state_d = ST_IDLE;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
    end
`endif
  end

  assign strobe = rise_d | fall_d;

  always_comb begin
    stretch_d = stretch_q;
    if (strobe)                 stretch_d = StW'(STRETCH_CYCLES);
    else if (stretch_q != '0)   stretch_d = stretch_q - 1'b1;
    ecount_d = ecount_q;
    if (clear)                              ecount_d = strobe ? COUNT_WIDTH'(1) : '0;
    else if (strobe && (ecount_q != '1))    ecount_d = ecount_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q     <= LVL_FLOAT;
      state_q   <= ST_IDLE;
      transit_q <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stretch_q <= '0;
      ecount_q  <= '0;
    end else begin
      lvl_q     <= lvl_d;
      state_q   <= state_d;
      transit_q <= transit_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stretch_q <= stretch_d;
      ecount_q  <= ecount_d;
    end
  end

`ifdef PROBE_FAULT_DETECT_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fault_q <= 1'b0;
    else if (clear) fault_q <= 1'b0;
    else if (lvl_d == LVL_FAULT) fault_q <= 1'b1;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign level_state = lvl_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign pulse_seen  = (stretch_q != '0);
  assign edge_count  = ecount_q;

endmodule

// File: tb/tb_probe_input_conditioner.sv
// Directed self-checking bench for probe_input_conditioner; honours PROBE_FAULT_DETECT_EN.
// A second instance with a 1-cycle filter exercises edge-counter saturation quickly.
module tb_probe_input_conditioner;
  import probe_pkg::*;

`ifdef PROBE_FAULT_DETECT_EN
  localparam logic [1:0] ExpDualLvl   = LVL_FAULT;
  localparam logic       ExpDualFault = 1'b1;
`else
  localparam logic [1:0] ExpDualLvl   = LVL_ONE;
  localparam logic       ExpDualFault = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic pulse_reset, hi, lo, clr;
  logic cdHi, cdLo, rise, fall, seen, flt;
  logic [1:0]  lvl;
  logic [15:0] cnt;

  logic sHi, sLo, sClr;
  logic sCdHi, sCdLo, sRise, sFall, sSeen, sFlt;
  logic [1:0]  sLvl;
  logic [15:0] sCnt;

  int checks = 0;
  int errors = 0;

  probe_input_conditioner #(.STRETCH_CYCLES(20)) dut (
    .clk(clk), .pulse_reset(pulse_reset), .comp_hi_raw(hi), .comp_lo_raw(lo), .clear(clr),
    .comp_data_hi(cdHi), .comp_data_lo(cdLo), .level_state(lvl), .rise_pulse(rise),
    .fall_pulse(fall), .pulse_seen(seen), .edge_count(cnt), .fault(flt)
  );

  probe_input_conditioner #(.FILTER_CYCLES(1), .STRETCH_CYCLES(20)) dutSat (
    .clk(clk), .pulse_reset(pulse_reset), .comp_hi_raw(sHi), .comp_lo_raw(sLo), .clear(sClr),
    .comp_data_hi(sCdHi), .comp_data_lo(sCdLo), .level_state(sLvl), .rise_pulse(sRise),
    .fall_pulse(sFall), .pulse_seen(sSeen), .edge_count(sCnt), .fault(sFlt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic h, input logic l);
    hi = h;
    lo = l;
  endtask

  task automatic monitorCycles(input int n, output int rises, output int falls,
                               output int seenCycles, output int cntAtStrobe);
    rises = 0; falls = 0; seenCycles = 0; cntAtStrobe = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("strobe_exclusive", 32'(rise & fall), 32'd0);
      if (rise) rises++;
      if (fall) falls++;
      if (seen) seenCycles++;
      if (rise | fall) cntAtStrobe = int'(cnt);
    end
  endtask

  int r, f, s, c, r2, f2, s2, c2;
  logic anyFlag;

  initial begin
    pulse_reset = 1'b1;
    hi = 1'b1; lo = 1'b0; clr = 1'b0;
    sHi = 1'b0; sLo = 1'b1; sClr = 1'b0;
    #1 pulse_reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cd_hi", 32'(cdHi), 32'd0);
    checkOutput("rst_level", 32'(lvl), 32'(LVL_FLOAT));
    checkOutput("rst_count", 32'(cnt), 32'd0);
    checkOutput("rst_seen", 32'(seen), 32'd0);
    checkOutput("rst_fault", 32'(flt), 32'd0);

    // Step to ONE: 2 cycles of reset release, then SYNC+FILTER = 6 cycles of latency
    pulse_reset = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("t1_hi_early", 32'(cdHi), 32'd0);
    @(negedge clk);
    checkOutput("t1_hi_latency", 32'(cdHi), 32'd1);
    checkOutput("t1_level_lag", 32'(lvl), 32'(LVL_FLOAT));
    @(negedge clk);
    checkOutput("t1_level_one", 32'(lvl), 32'(LVL_ONE));
    checkOutput("t1_no_rise", 32'(rise), 32'd0);
    checkOutput("t1_count", 32'(cnt), 32'd0);

    // ONE -> 20 FLOAT cycles -> ZERO: too slow to be an edge
    applyStimulus(1'b0, 1'b0);
    monitorCycles(20, r, f, s, c);
    applyStimulus(1'b0, 1'b1);
    monitorCycles(30, r2, f2, s2, c2);
    checkOutput("t4_no_fall", 32'(f + f2), 32'd0);
    checkOutput("t4_no_rise", 32'(r + r2), 32'd0);
    checkOutput("t4_count", 32'(cnt), 32'd0);
    checkOutput("t4_level_zero", 32'(lvl), 32'(LVL_ZERO));

    // 3-cycle HI glitch at ZERO
    anyFlag = 1'b0;
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cdHi || rise || fall) anyFlag = 1'b1;
    end
    checkOutput("t2_hi_glitch_rejected", 32'(anyFlag), 32'd0);

    // 3-cycle LO dropout is rejected, 4-cycle one passes the filter
    anyFlag = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cdLo) anyFlag = 1'b1;
    end
    checkOutput("t2_lo_dropout3", 32'(anyFlag), 32'd0);
    anyFlag = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    r = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cdLo) anyFlag = 1'b1;
      if (rise || fall) r++;
    end
    checkOutput("t2_lo_dropout4_passes", 32'(anyFlag), 32'd1);
    checkOutput("t2_dropout4_no_strobe", 32'(r), 32'd0);
    checkOutput("t2_level_zero", 32'(lvl), 32'(LVL_ZERO));

    // ZERO -> 5 FLOAT -> ONE: qualified rise, 20-cycle stretch
    applyStimulus(1'b0, 1'b0);
    monitorCycles(5, r, f, s, c);
    applyStimulus(1'b1, 1'b0);
    monitorCycles(40, r2, f2, s2, c2);
    checkOutput("t3_rise_once", 32'(r + r2), 32'd1);
    checkOutput("t3_no_fall", 32'(f + f2), 32'd0);
    checkOutput("t3_count_at_strobe", 32'(c2), 32'd1);
    checkOutput("t3_seen_cycles", 32'(s2), 32'd20);

    // ONE -> 9 FLOAT -> ZERO: last length inside the transit window
    applyStimulus(1'b0, 1'b0);
    monitorCycles(9, r, f, s, c);
    applyStimulus(1'b0, 1'b1);
    monitorCycles(40, r2, f2, s2, c2);
    checkOutput("t3_fall_window_edge", 32'(f + f2), 32'd1);
    checkOutput("t3_count2", 32'(cnt), 32'd2);
    checkOutput("t3_seen_cycles2", 32'(s2), 32'd20);

    // ZERO -> 10 FLOAT -> ONE: one cycle past the window, no edge
    applyStimulus(1'b0, 1'b0);
    monitorCycles(10, r, f, s, c);
    applyStimulus(1'b1, 1'b0);
    monitorCycles(30, r2, f2, s2, c2);
    checkOutput("t3_rise_past_window", 32'(r + r2), 32'd0);
    checkOutput("t3_count_hold", 32'(cnt), 32'd2);
    checkOutput("t3_level_one", 32'(lvl), 32'(LVL_ONE));

    // HI and LO together
    applyStimulus(1'b1, 1'b1);
    monitorCycles(12, r, f, s, c);
    checkOutput("t6_dual_level", 32'(lvl), 32'(ExpDualLvl));
    checkOutput("t6_dual_fault", 32'(flt), 32'(ExpDualFault));
    applyStimulus(1'b1, 1'b0);
    monitorCycles(12, r2, f2, s2, c2);
    checkOutput("t6_no_strobe", 32'(r + f + r2 + f2), 32'd0);
    checkOutput("t6_fault_sticky", 32'(flt), 32'(ExpDualFault));
    checkOutput("t6_level_back_one", 32'(lvl), 32'(LVL_ONE));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("t6_fault_cleared", 32'(flt), 32'd0);
    checkOutput("t6_count_cleared", 32'(cnt), 32'd0);

    // Saturation on the fast-filter instance: toggle ONE/ZERO every cycle
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      sHi = ~sHi;
      sLo = ~sLo;
    end
    repeat (10) @(negedge clk);
    checkOutput("t5_saturated", 32'(sCnt), 32'd65535);
    sClr = 1'b1;
    @(negedge clk);
    sClr = 1'b0;
    checkOutput("t5_clear_alone", 32'(sCnt), 32'd0);
    sHi = ~sHi;
    sLo = ~sLo;
    repeat (3) @(negedge clk);
    sClr = 1'b1;
    @(negedge clk);
    sClr = 1'b0;
    checkOutput("t5_clear_with_edge_strobe", 32'(sRise | sFall), 32'd1);
    checkOutput("t5_clear_with_edge", 32'(sCnt), 32'd1);

    // Asynchronous reset mid-operation, right after a fall on the main instance
    applyStimulus(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("rst2_pre_count", 32'(cnt), 32'd1);
    checkOutput("rst2_pre_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #2 pulse_reset = 1'b0;
    #1;
    checkOutput("rst2_cd_lo", 32'(cdLo), 32'd0);
    checkOutput("rst2_level", 32'(lvl), 32'(LVL_FLOAT));
    checkOutput("rst2_count", 32'(cnt), 32'd0);
    checkOutput("rst2_seen", 32'(seen), 32'd0);
    checkOutput("rst2_strobes", 32'(rise | fall), 32'd0);
    checkOutput("rst2_fault", 32'(flt), 32'd0);
    checkOutput("rst2_sat_count", 32'(sCnt), 32'd0);
    checkOutput("rst2_sat_cd_hi", 32'(sCdHi | sCdLo), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
